// File: rtl/apb_command_master.sv
// Single-outstanding APB4 requester: turns a valid/ready command stream into one
// SETUP/ACCESS transfer at a time and returns a buffered response with a watchdog abort.
module apb_command_master #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
  input  logic                     i_cmd_write,
  input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
  output logic                     o_rsp_error,
  output logic                     o_rsp_timeout,
  output logic                     o_psel,
  output logic                     o_penable,
  output logic                     o_pwrite,
  output logic [ADDRESS_WIDTH-1:0] o_paddr,
  output logic [2:0]               o_pprot,
  output logic [BUS_WIDTH-1:0]     o_pwdata,
  output logic [BUS_WIDTH/8-1:0]   o_pstrb,
  input  logic                     i_pready,
  input  logic                     i_pslverr,
  input  logic [BUS_WIDTH-1:0]     i_prdata,
  output logic                     o_busy
);

  localparam int STRB_WIDTH = BUS_WIDTH / 8;
  localparam int ALIGN_BITS = $clog2(STRB_WIDTH);
  // A disabled watchdog still gets a 1-bit counter so the declarations stay legal.
  localparam int CNT_WIDTH  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VALUE = CNT_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESPONSE} state_t;

  state_t               state, next_state;
  logic [CNT_WIDTH-1:0] wd_count;
  logic                 cmd_fire;
  logic                 timeout_hit;

  assign cmd_fire    = i_cmd_valid && (state == IDLE);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == ACCESS) && !i_pready &&
                       (wd_count == TIMEOUT_VALUE);
  assign o_pprot     = 3'b000;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (i_cmd_valid) next_state = SETUP;
      SETUP:    next_state = ACCESS;
      ACCESS:   if (i_pready || timeout_hit) next_state = RESPONSE;
      RESPONSE: if (i_rsp_ready) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    o_cmd_ready = 1'b0;
    o_psel      = 1'b0;
    o_penable   = 1'b0;
    o_rsp_valid = 1'b0;
    o_busy      = 1'b1;
    unique case (state)
      IDLE:     begin o_cmd_ready = 1'b1; o_busy = 1'b0; end
      SETUP:    o_psel = 1'b1;
      ACCESS:   begin o_psel = 1'b1; o_penable = 1'b1; end
      RESPONSE: o_rsp_valid = 1'b1;
      default:  o_busy = 1'b1;
    endcase
  end

  // Command latch: address aligned to the bus word, strobes zeroed for reads.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_paddr  <= '0;
      o_pwrite <= 1'b0;
      o_pwdata <= '0;
      o_pstrb  <= '0;
    end else if (cmd_fire) begin
      o_paddr  <= {i_cmd_address[ADDRESS_WIDTH-1:ALIGN_BITS], ALIGN_BITS'(0)};
      o_pwrite <= i_cmd_write;
      o_pwdata <= i_cmd_write_data;
      o_pstrb  <= i_cmd_write ? i_cmd_strobe : '0;
    end
  end

  // Response capture; a completing slave beats a coincident watchdog expiry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rsp_read_data <= '0;
      o_rsp_error     <= 1'b0;
      o_rsp_timeout   <= 1'b0;
    end else if (state == ACCESS && i_pready) begin
      o_rsp_read_data <= o_pwrite ? '0 : i_prdata;
      o_rsp_error     <= i_pslverr;
      o_rsp_timeout   <= 1'b0;
    end else if (timeout_hit) begin
      o_rsp_read_data <= '0;
      o_rsp_error     <= 1'b1;
      o_rsp_timeout   <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                          wd_count <= '0;
    else if (cmd_fire)                                  wd_count <= '0;
    else if (state == ACCESS && !i_pready && !timeout_hit) wd_count <= wd_count + 1'b1;
  end

endmodule

// File: tb/tb_apb_command_master.sv
// Scoreboard bench for apb_command_master: a driver queues expected responses, an APB
// slave model serves transfers, and a monitor compares every presented response.
module tb_apb_command_master;

  localparam int AW = 16;
  localparam int BW = 32;
  localparam int T  = 4;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_cmd_valid, o_cmd_ready, i_cmd_write;
  logic [AW-1:0] i_cmd_address;
  logic [BW-1:0] i_cmd_write_data;
  logic [3:0]    i_cmd_strobe;
  logic          o_rsp_valid, i_rsp_ready, o_rsp_error, o_rsp_timeout;
  logic [BW-1:0] o_rsp_read_data;
  logic          o_psel, o_penable, o_pwrite, o_busy;
  logic [AW-1:0] o_paddr;
  logic [2:0]    o_pprot;
  logic [BW-1:0] o_pwdata, i_prdata;
  logic [3:0]    o_pstrb;
  logic          i_pready, i_pslverr;

  apb_command_master #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_address(i_cmd_address), .i_cmd_write(i_cmd_write),
    .i_cmd_write_data(i_cmd_write_data), .i_cmd_strobe(i_cmd_strobe),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_read_data(o_rsp_read_data), .o_rsp_error(o_rsp_error),
    .o_rsp_timeout(o_rsp_timeout),
    .o_psel(o_psel), .o_penable(o_penable), .o_pwrite(o_pwrite),
    .o_paddr(o_paddr), .o_pprot(o_pprot), .o_pwdata(o_pwdata), .o_pstrb(o_pstrb),
    .i_pready(i_pready), .i_pslverr(i_pslverr), .i_prdata(i_prdata),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [BW-1:0] wdata;
    logic [3:0]    strb;
    int            w;
    logic          err;
    logic [BW-1:0] prdata;
  } slv_t;

  typedef struct {
    logic [BW-1:0] data;
    logic          err;
    logic          to;
    int            lat;
    int            hold;
    int            hs;
  } exp_t;

  slv_t slv_q[$];
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_rsp_hs = -100;
  int   rsp_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Reference behaviour: slave completes after w wait states unless the watchdog
  // (T counted wait states) expires first; pready on the expiry cycle still wins.
  task automatic send(input logic [AW-1:0] a, input logic wr, input logic [BW-1:0] d,
                      input logic [3:0] s, input int w, input logic e,
                      input logic [BW-1:0] rd, input int hold, output int hs);
    slv_t sv;
    exp_t ev;
    int   n;
    @(negedge clk);
    i_cmd_valid      = 1'b1;
    i_cmd_address    = a;
    i_cmd_write      = wr;
    i_cmd_write_data = d;
    i_cmd_strobe     = s;
    n = 0;
    while (!o_cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!o_cmd_ready) begin
      bound_fail("cmd_accept");
      i_cmd_valid = 1'b0;
      hs = -1;
      return;
    end
    hs = cyc;
    sv.addr = {a[AW-1:2], 2'b00};
    sv.wr = wr; sv.wdata = d; sv.strb = wr ? s : 4'h0;
    sv.w = w; sv.err = e; sv.prdata = rd;
    slv_q.push_back(sv);
    ev.to   = (w > T);
    ev.err  = (w > T) ? 1'b1 : e;
    ev.data = ((w > T) || wr) ? '0 : rd;
    ev.lat  = 3 + ((w > T) ? T : w);
    ev.hold = hold;
    ev.hs   = hs;
    exp_q.push_back(ev);
    @(posedge clk);
    #1 i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || o_busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) bound_fail("wait_idle");
  endtask

  // APB slave model.
  initial begin
    slv_t cur;
    int   acc = 0;
    bit   in_access = 0;
    cur = '{default: '0};
    forever begin
      @(negedge clk);
      if (o_psel && !o_penable) begin
        if (slv_q.size() == 0) begin
          bound_fail("unexpected_setup");
        end else begin
          cur = slv_q.pop_front();
        end
        acc = 0;
        check("setup_paddr", o_paddr, cur.addr);
        check("setup_pwrite", o_pwrite, cur.wr);
        check("setup_pstrb", o_pstrb, cur.strb);
        if (cur.wr) check("setup_pwdata", o_pwdata, cur.wdata);
        i_pready = 1'($urandom);
      end else if (o_psel && o_penable) begin
        in_access = 1;
        acc++;
        check("access_paddr", o_paddr, cur.addr);
        check("access_pstrb", o_pstrb, cur.strb);
        if (acc == cur.w + 1) begin
          i_pready  = 1'b1;
          i_prdata  = cur.prdata;
          i_pslverr = cur.err;
        end else begin
          i_pready  = 1'b0;
          i_prdata  = $urandom;
          i_pslverr = 1'($urandom);
        end
      end else begin
        if (in_access && !i_rst)
          check("access_cycles", acc, ((cur.w > T) ? T : cur.w) + 1);
        in_access = 0;
        i_pready  = 1'($urandom);
        i_prdata  = $urandom;
        i_pslverr = 1'($urandom);
      end
    end
  end

  // Response monitor / scoreboard.
  initial begin
    exp_t cur;
    bit   have = 0;
    int   hold = 0;
    cur = '{default: '0};
    i_rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (o_rsp_valid) begin
        if (!have) begin
          rsp_seen++;
          if (exp_q.size() == 0) begin
            bound_fail("unexpected_rsp");
            cur = '{default: '0};
          end else begin
            cur = exp_q.pop_front();
            check("rsp_latency", cyc - cur.hs, cur.lat);
          end
          have = 1;
          hold = cur.hold;
        end
        check("rsp_data", o_rsp_read_data, cur.data);
        check("rsp_error", o_rsp_error, cur.err);
        check("rsp_timeout", o_rsp_timeout, cur.to);
        check("rsp_psel_low", o_psel, 1'b0);
        check("rsp_cmd_ready_low", o_cmd_ready, 1'b0);
        check("rsp_busy", o_busy, 1'b1);
        if (hold == 0) begin
          i_rsp_ready = 1'b1;
          last_rsp_hs = cyc;
          have = 0;
        end else begin
          i_rsp_ready = 1'b0;
          hold--;
        end
      end else begin
        have = 0;
        i_rsp_ready = 1'($urandom);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hs, hs2, n, snap;
    i_rst = 1'b1;
    i_cmd_valid = 1'b0; i_cmd_address = '0; i_cmd_write = 1'b0;
    i_cmd_write_data = '0; i_cmd_strobe = '0;
    i_pready = 1'b0; i_pslverr = 1'b0; i_prdata = '0;
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", o_cmd_ready, 1'b1);
    check("reset_psel", o_psel, 1'b0);
    check("reset_penable", o_penable, 1'b0);
    check("reset_rsp_valid", o_rsp_valid, 1'b0);
    check("reset_busy", o_busy, 1'b0);
    check("reset_pprot", o_pprot, 3'b000);
    check("reset_paddr", o_paddr, 16'h0000);
    check("reset_rsp_error", o_rsp_error, 1'b0);
    i_rst = 1'b0;

    // Directed cases: zero-wait write, 2-wait read, slave error, watchdog, coincident pready.
    send(16'h0013, 1'b1, 32'hA5A5_5A5A, 4'b0011, 0, 1'b0, 32'h1111_2222, 0, hs);
    send(16'h0040, 1'b0, 32'h0,         4'b1111, 2, 1'b0, 32'hDEAD_BEEF, 0, hs);
    send(16'h0084, 1'b0, 32'h0,         4'b1111, 0, 1'b1, 32'h5555_AAAA, 0, hs);
    send(16'h00C8, 1'b0, 32'h0,         4'b0000, 50, 1'b0, 32'h7777_7777, 0, hs);
    send(16'h0100, 1'b0, 32'h0,         4'b0000, T, 1'b0, 32'h1234_5678, 0, hs);
    // Backpressure: response held 10 cycles while the next command waits.
    send(16'h0204, 1'b1, 32'hCAFE_F00D, 4'b1001, 1, 1'b0, 32'h0, 10, hs);
    send(16'h0208, 1'b0, 32'h0,         4'b1111, 0, 1'b0, 32'hBEEF_0001, 0, hs2);
    check("accept_after_rsp_handshake", hs2, last_rsp_hs + 1);
    wait_idle();

    // Reset in the middle of ACCESS aborts without a response.
    send(16'h0300, 1'b0, 32'h0, 4'b0000, 50, 1'b0, 32'h0, 0, hs);
    n = 0;
    while (!o_penable && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!o_penable) bound_fail("reach_access");
    @(negedge clk);
    #2 i_rst = 1'b1;
    #1;
    check("midreset_psel", o_psel, 1'b0);
    check("midreset_penable", o_penable, 1'b0);
    check("midreset_cmd_ready", o_cmd_ready, 1'b1);
    check("midreset_busy", o_busy, 1'b0);
    exp_q.delete();
    slv_q.delete();
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    snap = rsp_seen;
    repeat (12) @(negedge clk);
    check("no_rsp_after_reset", rsp_seen - snap, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      send(AW'($urandom), 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 6),
           ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3), hs);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
